// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one datamemory port between two requesters, registering the winner
// and issuing a single-cycle memory strobe followed by a per-port ack/err pulse.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [DM_ADDRESS-1:0] p0_addr,
  input  logic [DATA_W-1:0]     p0_wdata,
  input  logic [2:0]            p0_funct3,
  output logic                  p0_ack,
  output logic                  p0_err,
  output logic [DATA_W-1:0]     p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [DM_ADDRESS-1:0] p1_addr,
  input  logic [DATA_W-1:0]     p1_wdata,
  input  logic [2:0]            p1_funct3,
  output logic                  p1_ack,
  output logic                  p1_err,
  output logic [DATA_W-1:0]     p1_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rd
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic ptr, id_r, we_r, err_r;
  logic [DM_ADDRESS-1:0] addr_r;
  logic [DATA_W-1:0] wd_r;
  logic [2:0] f3_r;
  logic grant, win, win_we, legal, acc;
  logic [DM_ADDRESS-1:0] win_addr;
  logic [DATA_W-1:0] win_wd;
  logic [2:0] win_f3;

  function automatic logic legal_f(logic we, logic [1:0] a, logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001 && !a[0]) || (f3 == 3'b010 && a == 2'b00) ||
           (!we && (f3 == 3'b100 || (f3 == 3'b101 && !a[0])));
  endfunction

  always_comb begin
    grant = (state == IDLE) && (p0_req || p1_req);
    win = (p0_req && p1_req) ? ptr : p1_req;
    win_we = win ? p1_we : p0_we;
    win_addr = win ? p1_addr : p0_addr;
    win_wd = win ? p1_wdata : p0_wdata;
    win_f3 = win ? p1_funct3 : p0_funct3;
    legal = legal_f(win_we, win_addr[1:0], win_f3);
    state_nx = state;
    state_nx = (state == ACCESS) ? DONE :
               (state == DONE) ? IDLE :
               grant ? (legal ? ACCESS : DONE) : IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= 1'b0;
      id_r <= 1'b0;
      we_r <= 1'b0;
      err_r <= 1'b0;
      addr_r <= '0;
      wd_r <= '0;
      f3_r <= '0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        ptr <= ~win;
        id_r <= win;
        we_r <= win_we;
        err_r <= ~legal;
        addr_r <= win_addr;
        wd_r <= win_wd;
        f3_r <= win_f3;
      end
      if (state == ACCESS && !we_r && !id_r) p0_rdata <= mem_rd;
      if (state == ACCESS && !we_r && id_r) p1_rdata <= mem_rd;
    end
  end

  assign acc = (state == ACCESS);
  assign mem_read = acc & ~we_r;
  assign mem_write = acc & we_r;
  assign mem_a = acc ? addr_r : '0;
  assign mem_wd = acc ? wd_r : '0;
  assign mem_funct3 = acc ? f3_r : '0;
  assign p0_ack = (state == DONE) & ~id_r;
  assign p1_ack = (state == DONE) & id_r;
  assign p0_err = p0_ack & err_r;
  assign p1_err = p1_ack & err_r;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random requests on both ports, checked every cycle
// against a transaction-level model of arbitration, timing and memory contents.
module tb_dmem_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [2:0]    f3;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic req_v [2];
  req_t cur [2];
  logic p0_ack, p0_err, p1_ack, p1_err, mem_read, mem_write;
  logic [DW-1:0] p0_rdata, p1_rdata, mem_wd, mem_rd;
  logic [AW-1:0] mem_a;
  logic [2:0] mem_funct3;

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(req_v[0]), .p0_we(cur[0].we), .p0_addr(cur[0].addr), .p0_wdata(cur[0].wdata),
    .p0_funct3(cur[0].f3), .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(req_v[1]), .p1_we(cur[1].we), .p1_addr(cur[1].addr), .p1_wdata(cur[1].wdata),
    .p1_funct3(cur[1].f3), .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_funct3(mem_funct3), .mem_rd(mem_rd)
  );

  // datamemory stand-in: combinational read, write on the rising edge
  logic [7:0] tb_mem [512];
  logic [7:0] ref_mem [512];

  function automatic logic [31:0] ext(logic [31:0] raw, logic [2:0] f3);
    case (f3[1:0])
      2'd0: return f3[2] ? {24'b0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
      2'd1: return f3[2] ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  assign mem_rd = mem_read ? ext({tb_mem[mem_a+9'd3], tb_mem[mem_a+9'd2], tb_mem[mem_a+9'd1],
                                  tb_mem[mem_a]}, mem_funct3) : 32'hA5A55A5A;

  always @(posedge clk)
    if (mem_write)
      for (int k = 0; k < 4; k++)
        if (k < (1 << mem_funct3[1:0])) tb_mem[mem_a+9'(k)] <= mem_wd[8*k+:8];

  int errors = 0, checks = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: transaction bookkeeping with plain arithmetic
  bit busy = 0, g_ok = 0, rnd_mode = 0;
  int t = 0, ack_t = 0, win = 0, ptr = 0;
  req_t g;
  logic [31:0] rd_val;
  logic [31:0] exp_rdata [2];
  req_t q0 [$], q1 [$];
  int order [$];

  function automatic bit legal(req_t r);
    int sz = int'(r.f3[1:0]);
    return !(sz == 3 || (r.f3[2] && (sz == 2 || r.we)) || (int'(r.addr) % (1 << sz)) != 0);
  endfunction

  function automatic logic [31:0] load(req_t r);
    int n = 1 << r.f3[1:0];
    logic [31:0] raw, mask, v;
    for (int k = 0; k < 4; k++) raw[8*k+:8] = ref_mem[(int'(r.addr) + k) % 512];
    mask = (n == 4) ? 32'hFFFFFFFF : (32'd1 << (8 * n)) - 32'd1;
    v = raw & mask;
    if (!r.f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic store(req_t r);
    int n = 1 << r.f3[1:0];
    for (int k = 0; k < n; k++) ref_mem[(int'(r.addr) + k) % 512] = 8'(r.wdata >> (8 * k));
  endtask

  task automatic model();
    if (!rst_n) begin
      busy = 0;
      ptr = 0;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
    end else if (busy && t == ack_t) busy = 0;
    else if (busy) begin
      t++;
      if (t == ack_t && !g.we) exp_rdata[win] = rd_val;
    end else if (req_v[0] || req_v[1]) begin
      win = (req_v[0] && req_v[1]) ? ptr : (req_v[1] ? 1 : 0);
      ptr = 1 - win;
      g = cur[win];
      g_ok = legal(g);
      ack_t = g_ok ? 2 : 1;
      t = 1;
      busy = 1;
      if (g_ok && g.we) store(g);
      if (g_ok && !g.we) rd_val = load(g);
    end
  endtask

  task automatic check();
    bit acc, ak;
    acc = busy && g_ok && t == 1;
    ak = busy && t == ack_t;
    chk("p0_ack", 32'(p0_ack), 32'(ak && win == 0));
    chk("p1_ack", 32'(p1_ack), 32'(ak && win == 1));
    chk("p0_err", 32'(p0_err), 32'(ak && win == 0 && !g_ok));
    chk("p1_err", 32'(p1_err), 32'(ak && win == 1 && !g_ok));
    chk("p0_rdata", p0_rdata, exp_rdata[0]);
    chk("p1_rdata", p1_rdata, exp_rdata[1]);
    chk("mem_read", 32'(mem_read), 32'(acc && !g.we));
    chk("mem_write", 32'(mem_write), 32'(acc && g.we));
    chk("mem_a", 32'(mem_a), acc ? 32'(g.addr) : 32'd0);
    chk("mem_wd", mem_wd, acc ? g.wdata : 32'd0);
    chk("mem_funct3", 32'(mem_funct3), acc ? 32'(g.f3) : 32'd0);
    if (p0_ack) order.push_back(0);
    if (p1_ack) order.push_back(1);
  endtask

  function automatic req_t rand_req();
    req_t r;
    logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    r.we = 1'($urandom);
    r.f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) :
           r.we ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 4)];
    r.addr = AW'($urandom);
    if ($urandom_range(0, 3) != 0) r.addr = (r.addr >> r.f3[1:0]) << r.f3[1:0];
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic drive();
    bit ak;
    ak = busy && t == ack_t;
    for (int p = 0; p < 2; p++) begin
      if (ak && win == p) req_v[p] = 1'b0;
      if (!req_v[p]) begin
        if (p == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); req_v[0] = 1'b1; end
        else if (p == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); req_v[1] = 1'b1; end
        else if (rnd_mode && $urandom_range(0, 2) == 0) begin cur[p] = rand_req(); req_v[p] = 1'b1; end
      end else if (rnd_mode && !(busy && win == p) && $urandom_range(0, 7) == 0) cur[p] = rand_req();
    end
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    check();
    drive();
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    q0.delete();
    q1.delete();
    step();
    rst_n = 1'b1;
  endtask

  task automatic poke(int a, logic [7:0] b);
    tb_mem[a] = b;
    ref_mem[a] = b;
  endtask

  task automatic chk_order(string tag, int exp [$]);
    chk({tag, "_n"}, 32'(order.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk(tag, (i < order.size()) ? 32'(order[i]) : 32'hFFFFFFFF, 32'(exp[i]));
  endtask

  initial begin
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    cur[0] = '0;
    cur[1] = '0;
    for (int i = 0; i < 512; i++) poke(i, 8'($urandom));
    do_reset();
    run(2);
    // single load of a known word
    poke(16, 8'hEF); poke(17, 8'hBE); poke(18, 8'hAD); poke(19, 8'hDE);
    q0.push_back('{1'b0, 9'h010, 32'h0, 3'b010});
    run(6);
    chk("lw_data", p0_rdata, 32'hDEADBEEF);
    // simultaneous contests alternate starting with port 0
    do_reset();
    order.delete();
    q0.push_back('{1'b1, 9'h020, 32'h11111111, 3'b010});
    q1.push_back('{1'b1, 9'h024, 32'h22222222, 3'b010});
    for (int i = 0; i < 2; i++) begin
      q0.push_back(rand_req());
      q1.push_back(rand_req());
    end
    run(24);
    chk_order("alt", '{0, 1, 0, 1, 0, 1});
    q0.push_back('{1'b0, 9'h020, 32'h0, 3'b010});
    run(5);
    q1.push_back('{1'b0, 9'h024, 32'h0, 3'b010});
    run(5);
    chk("sw0_back", p0_rdata, 32'h11111111);
    chk("sw1_back", p1_rdata, 32'h22222222);
    // misaligned half, bad store encoding, byte sign handling
    q1.push_back('{1'b0, 9'h003, 32'h0, 3'b001});
    run(5);
    q0.push_back('{1'b1, 9'h030, 32'hCAFEF00D, 3'b011});
    run(5);
    poke(49, 8'h80);
    q0.push_back('{1'b0, 9'h031, 32'h0, 3'b000});
    run(5);
    chk("lb_sign", p0_rdata, 32'hFFFFFF80);
    q0.push_back('{1'b0, 9'h031, 32'h0, 3'b100});
    run(5);
    chk("lbu_zero", p0_rdata, 32'h00000080);
    // reset in the middle of a port 1 read
    q1.push_back('{1'b0, 9'h040, 32'h0, 3'b010});
    for (int i = 0; i < 10 && !(mem_read && busy && win == 1); i++) step();
    chk("abort_access", 32'(mem_read), 32'd1);
    rst_n = 1'b0;
    req_v[1] = 1'b0;
    step();
    rst_n = 1'b1;
    order.delete();
    q0.push_back(rand_req());
    q1.push_back(rand_req());
    run(10);
    chk_order("post_rst", '{0, 1});
    // back-to-back port 1 stream with port 0 joining mid-stream
    order.delete();
    for (int i = 0; i < 4; i++) q1.push_back('{1'b0, AW'(4 * i), 32'h0, 3'b010});
    run(2);
    q0.push_back('{1'b1, 9'h100, 32'h5A5A5A5A, 3'b010});
    run(18);
    chk_order("stream", '{1, 0, 1, 1, 1});
    // random traffic
    rnd_mode = 1;
    run(3000);
    rnd_mode = 0;
    run(12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
